// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: default geometry shared by the FIFO and its integrators
package sync_fifo_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;
endpackage

// File: rtl/fifo_storage.sv
// fifo_storage: register array with synchronous write and asynchronous read
module fifo_storage #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end
  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: first-word fall-through FIFO with status flags and sticky overflow
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [WIDTH-1:0] rd_data;
  logic push, pop, wr_en;
  fifo_storage #(WIDTH, DEPTH) u_storage (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (in_data),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );
  always_comb begin
    full        = count == CW'(DEPTH);
    empty       = count == '0;
    almost_full = count >= CW'(AF_LEVEL);
    in_ready    = ~full;
    out_valid   = ~empty;
    push        = in_valid & in_ready;
    pop         = out_valid & out_ready;
    wr_en       = push & ~flush & ~reset;
    out_data    = empty ? '0 : rd_data;
  end
  // flush outranks push/pop but leaves the storage array alone
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      if (in_valid & full) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: queue-model checked FIFO bench with directed and random traffic
module tb_sync_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AF = 3;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid, full, empty, almost_full, overflow;
  logic [WIDTH-1:0] out_data;
  logic [2:0] count;
  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] q[$];
  logic m_ov = 1'b0;
  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .overflow    (overflow)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask
  // reference: a queue of words plus a sticky overflow bit
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      q.delete();
      m_ov = 1'b0;
    end else if (flush) begin
      q.delete();
      m_ov = 1'b0;
    end else begin
      automatic bit can_push = in_valid && q.size() < DEPTH;
      automatic bit can_pop = out_ready && q.size() > 0;
      if (in_valid && q.size() == DEPTH) m_ov = 1'b1;
      if (can_pop) void'(q.pop_front());
      if (can_push) q.push_back(in_data);
    end
  end
  always @(negedge clock) begin
    if (!reset) begin
      automatic int n = q.size();
      chk("count", 32'(count), 32'(n));
      chk("empty", 32'(empty), 32'(n == 0));
      chk("full", 32'(full), 32'(n == DEPTH));
      chk("almost_full", 32'(almost_full), 32'(n >= AF));
      chk("in_ready", 32'(in_ready), 32'(n < DEPTH));
      chk("out_valid", 32'(out_valid), 32'(n > 0));
      chk("out_data", 32'(out_data), n > 0 ? 32'(q[0]) : 32'd0);
      chk("overflow", 32'(overflow), 32'(m_ov));
    end
  end
  task automatic drive(input logic v, input logic [7:0] d, input logic r, input logic f);
    in_valid = v;
    in_data = d;
    out_ready = r;
    flush = f;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    flush = 1'b0;
  endtask
  initial begin
    #1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_full_af", 32'({full, almost_full, overflow}), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    drive(1, 8'h11, 0, 0);
    chk("first_latency_data", 32'(out_data), 32'h11);
    drive(1, 8'h22, 0, 0);
    chk("two_count", 32'(count), 32'd2);
    chk("two_head", 32'(out_data), 32'h11);
    chk("two_valid", 32'({out_valid, empty}), 32'b10);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    chk("drained", 32'(empty), 32'd1);
    for (int i = 0; i < 4; i++) begin
      drive(1, 8'hA0 + 8'(i), 0, 0);
      if (i == 2) chk("af_at_3", 32'({almost_full, full}), 32'b10);
    end
    chk("full_flags", 32'({full, in_ready, almost_full}), 32'b101);
    drive(1, 8'hFF, 0, 0);
    chk("overflow_set", 32'(overflow), 32'd1);
    chk("overflow_count", 32'(count), 32'd4);
    drive(1, 8'hEE, 1, 0);
    chk("no_full_bypass", 32'(count), 32'd3);
    for (int i = 1; i < 4; i++) begin
      chk("pop_order", 32'(out_data), 32'hA0 + 32'(i));
      drive(0, 0, 1, 0);
    end
    chk("pop_empty", 32'({empty, out_data}), 32'h100);
    chk("overflow_sticky", 32'(overflow), 32'd1);
    drive(0, 0, 0, 1);
    chk("flush_clears_ov", 32'(overflow), 32'd0);
    drive(1, 8'h55, 0, 0);
    for (int i = 0; i < 10; i++) begin
      chk("stream_head", 32'(out_data), i == 0 ? 32'h55 : 32'(i - 1));
      drive(1, 8'(i), 1, 0);
      chk("stream_count", 32'(count), 32'd1);
    end
    drive(1, 8'h31, 0, 0);
    drive(1, 8'h32, 0, 0);
    chk("pre_flush_count", 32'(count), 32'd3);
    drive(1, 8'h77, 1, 1);
    chk("flush_result", 32'({count, empty, overflow}), 32'b000_1_0);
    drive(1, 8'h41, 0, 0);
    drive(1, 8'h42, 0, 0);
    chk("pre_reset_count", 32'(count), 32'd2);
    #3 reset = 1'b1;
    #1;
    chk("async_reset", 32'({empty, count, out_valid}), 32'b1_000_0);
    @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      automatic int mode = (i / 300) % 3;
      automatic logic v = $urandom_range(99) < (mode == 0 ? 80 : mode == 1 ? 30 : 55);
      automatic logic r = $urandom_range(99) < (mode == 0 ? 30 : mode == 1 ? 80 : 55);
      automatic logic f = $urandom_range(199) == 0;
      drive(v, 8'($urandom), r, f);
    end
    @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
